// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory controller slice.
//   state_t       : controller states (RUN, LOAD, DONE)
//   MEM_BYTES_DEF : default instruction memory size in bytes
//   WORD_BYTES    : bytes per instruction word
//   addr_fault()  : word-access legality check, evaluated in 64 bits so an
//                   address close to the top of the address space cannot wrap
//                   into range
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int MEM_BYTES_DEF = 128;
    localparam int WORD_BYTES    = 4;

    // A word access faults when it is not word aligned or when its last byte
    // lies beyond the end of the memory.
    function automatic logic addr_fault(input logic [63:0] addr,
                                        input logic [63:0] mem_bytes);
        return (addr[1:0] != 2'b00) ||
               ((addr + 64'(WORD_BYTES - 1)) > (mem_bytes - 64'd1));
    endfunction

endpackage

// File: rtl/imem_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a one-bit priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbitration enabled; no grant is issued while low
//   clr        : force the pointer back to favouring requester 0
//   req[1:0]   : requests (bit 0 = fetch, bit 1 = debug read)
//   gnt[1:0]   : one-hot grant, combinational from req and the pointer
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // ptr = 0 favours requester 0, ptr = 1 favours requester 1
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // After any grant the other requester gets priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (clr) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
// Sequencer/arbiter in front of the byte-organised, big-endian instruction
// memory. Shares the memory between the IF fetch port and the debug unit, and
// lets the debug unit stream a program in byte by byte while the pipeline is
// stalled.
//
// Ports
//   clk, rst_n                        : clock, asynchronous active-low reset
//   fetch_req/addr -> fetch_instr/valid/fault, fetch_stall : IF port
//   dbg_rd_req/addr -> dbg_rd_data/valid : debug word read
//   dbg_load_start/len, dbg_byte/valid -> dbg_byte_ready  : program load
//   load_done, load_ovf, load_checksum : load status
//   mem_addr, mem_we, mem_wbyte (registered), mem_rword : memory array side
//
// Read timing: a grant registers mem_addr; the memory returns the word during
// the following cycle and it is registered onto *_instr/*_data with a one
// cycle *_valid pulse at the next edge.
//
// Build option: define IMEM_CHECKSUM_EN to get an 8-bit running sum of every
// accepted load byte on load_checksum; otherwise load_checksum is tied to 0.
// -----------------------------------------------------------------------------
module imem_ctrl
    import imem_pkg::*;
#(
    parameter int BITS_DIR  = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int LEN_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_req,
    input  logic [BITS_DIR-1:0] fetch_addr,
    output logic [BITS_DIR-1:0] fetch_instr,
    output logic                fetch_valid,
    output logic                fetch_stall,
    output logic                fetch_fault,
    input  logic                dbg_rd_req,
    input  logic [BITS_DIR-1:0] dbg_rd_addr,
    output logic [BITS_DIR-1:0] dbg_rd_data,
    output logic                dbg_rd_valid,
    input  logic                dbg_load_start,
    input  logic [LEN_W-1:0]    dbg_load_len,
    input  logic [7:0]          dbg_byte,
    input  logic                dbg_byte_valid,
    output logic                dbg_byte_ready,
    output logic                load_done,
    output logic                load_ovf,
    output logic [BITS_DIR-1:0] mem_addr,
    output logic                mem_we,
    output logic [7:0]          mem_wbyte,
    input  logic [BITS_DIR-1:0] mem_rword,
    output logic [7:0]          load_checksum
);

    state_t              state;
    state_t              state_nxt;
    logic [LEN_W-1:0]    load_len;
    logic [LEN_W-1:0]    load_cnt;
    logic [BITS_DIR-1:0] load_addr;
    logic                pend_fetch;
    logic                pend_dbg;
    logic                pend_fault;
    logic [1:0]          gnt;
    logic                arb_en;
    logic                fetch_flt;
    logic                dbg_flt;
    logic                load_full;
    logic                load_begin;
    logic                byte_take;
    logic                in_range;

    assign fetch_flt  = addr_fault(64'(fetch_addr), 64'(MEM_BYTES));
    assign dbg_flt    = addr_fault(64'(dbg_rd_addr), 64'(MEM_BYTES));
    assign load_full  = (load_cnt == load_len);
    assign load_begin = (state == ST_RUN) && dbg_load_start;
    assign byte_take  = dbg_byte_ready && dbg_byte_valid;
    assign in_range   = (load_addr < BITS_DIR'(MEM_BYTES));

    // No new reads are granted in the cycle a load is started.
    assign arb_en = (state == ST_RUN) && !dbg_load_start;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .clr   (state == ST_DONE),
        .req   ({dbg_rd_req, fetch_req}),
        .gnt   (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // LOAD leaves one edge after the last byte is taken, so the final
    // registered write strobe has already dropped when load_done is shown.
    always_comb begin
        state_nxt      = state;
        fetch_stall    = 1'b1;
        dbg_byte_ready = 1'b0;
        load_done      = 1'b0;
        case (state)
            ST_RUN: begin
                fetch_stall = fetch_req && !gnt[0];
                if (dbg_load_start) begin
                    state_nxt = (dbg_load_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                dbg_byte_ready = !load_full;
                if (load_full) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                load_done = 1'b1;
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Read pipeline, load address/counter and the registered memory strobes.
    // A faulting read leaves mem_addr untouched and returns 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wbyte    <= 8'h00;
            pend_fetch   <= 1'b0;
            pend_dbg     <= 1'b0;
            pend_fault   <= 1'b0;
            fetch_valid  <= 1'b0;
            fetch_fault  <= 1'b0;
            fetch_instr  <= '0;
            dbg_rd_valid <= 1'b0;
            dbg_rd_data  <= '0;
            load_len     <= '0;
            load_cnt     <= '0;
            load_addr    <= '0;
            load_ovf     <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            pend_fetch <= gnt[0];
            pend_dbg   <= gnt[1];
            pend_fault <= gnt[0] ? fetch_flt : (gnt[1] && dbg_flt);
            if (gnt[0] && !fetch_flt) begin
                mem_addr <= fetch_addr;
            end else if (gnt[1] && !dbg_flt) begin
                mem_addr <= dbg_rd_addr;
            end

            fetch_valid  <= pend_fetch;
            fetch_fault  <= pend_fetch && pend_fault;
            dbg_rd_valid <= pend_dbg;
            if (pend_fetch) begin
                fetch_instr <= pend_fault ? '0 : mem_rword;
            end
            if (pend_dbg) begin
                dbg_rd_data <= pend_fault ? '0 : mem_rword;
            end

            if (load_begin) begin
                load_len  <= dbg_load_len;
                load_cnt  <= '0;
                load_addr <= '0;
                load_ovf  <= 1'b0;
            end

            // Bytes past the end of memory are counted but never written.
            if (byte_take) begin
                load_cnt  <= load_cnt + LEN_W'(1);
                load_addr <= load_addr + BITS_DIR'(1);
                if (in_range) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= load_addr;
                    mem_wbyte <= dbg_byte;
                end else begin
                    load_ovf <= 1'b1;
                end
            end
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] csum;

    // Running modulo-256 sum of all accepted bytes, dropped ones included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (load_begin) begin
            csum <= 8'h00;
        end else if (byte_take) begin
            csum <= csum + dbg_byte;
        end
    end

    assign load_checksum = csum;
`else
    assign load_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_ctrl
// Self-checking bench for imem_ctrl with a behavioural 128-byte big-endian
// memory. A vector table covers fetch/debug reads, arbitration and faults;
// hand-written sequences cover loads, overflow, zero-length load and reset
// in the middle of a load. Honours IMEM_CHECKSUM_EN when defined.
// -----------------------------------------------------------------------------
module tb_imem_ctrl;

    localparam int BITS_DIR  = 32;
    localparam int MEM_BYTES = 128;
    localparam int LEN_W     = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                fetch_req = 1'b0;
    logic [BITS_DIR-1:0] fetch_addr = '0;
    logic [BITS_DIR-1:0] fetch_instr;
    logic                fetch_valid;
    logic                fetch_stall;
    logic                fetch_fault;
    logic                dbg_rd_req = 1'b0;
    logic [BITS_DIR-1:0] dbg_rd_addr = '0;
    logic [BITS_DIR-1:0] dbg_rd_data;
    logic                dbg_rd_valid;
    logic                dbg_load_start = 1'b0;
    logic [LEN_W-1:0]    dbg_load_len = '0;
    logic [7:0]          dbg_byte = 8'h00;
    logic                dbg_byte_valid = 1'b0;
    logic                dbg_byte_ready;
    logic                load_done;
    logic                load_ovf;
    logic [BITS_DIR-1:0] mem_addr;
    logic                mem_we;
    logic [7:0]          mem_wbyte;
    logic [BITS_DIR-1:0] mem_rword;
    logic [7:0]          load_checksum;

    imem_ctrl #(
        .BITS_DIR  (BITS_DIR),
        .MEM_BYTES (MEM_BYTES),
        .LEN_W     (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_instr    (fetch_instr),
        .fetch_valid    (fetch_valid),
        .fetch_stall    (fetch_stall),
        .fetch_fault    (fetch_fault),
        .dbg_rd_req     (dbg_rd_req),
        .dbg_rd_addr    (dbg_rd_addr),
        .dbg_rd_data    (dbg_rd_data),
        .dbg_rd_valid   (dbg_rd_valid),
        .dbg_load_start (dbg_load_start),
        .dbg_load_len   (dbg_load_len),
        .dbg_byte       (dbg_byte),
        .dbg_byte_valid (dbg_byte_valid),
        .dbg_byte_ready (dbg_byte_ready),
        .load_done      (load_done),
        .load_ovf       (load_ovf),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wbyte      (mem_wbyte),
        .mem_rword      (mem_rword),
        .load_checksum  (load_checksum)
    );

    always #5 clk = ~clk;

    // Behavioural memory plus a log of every write strobe seen.
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic        preload_now = 1'b0;
    logic        bad_write = 1'b0;
    int          write_count = 0;
    logic [31:0] wr_log_addr [0:511];
    logic [7:0]  wr_log_byte [0:511];
    logic [6:0]  rd_base;

    function automatic logic [7:0] init_byte(input int idx);
        logic [31:0] w;
        case (idx / 4)
            1:       w = 32'h8C220004;
            2:       w = 32'h11223344;
            3:       w = 32'hDEADBEEF;
            4:       w = 32'h13579BDF;
            31:      w = 32'hCAFEF00D;
            default: w = 32'h00000000;
        endcase
        return w[8*(3 - (idx % 4)) +: 8];
    endfunction

    always @(posedge clk) begin
        if (preload_now) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
        end else if (mem_we) begin
            if (mem_addr >= 32'(MEM_BYTES)) bad_write <= 1'b1;
            else mem[mem_addr[6:0]] <= mem_wbyte;
            if (write_count < 512) begin
                wr_log_addr[write_count] <= mem_addr;
                wr_log_byte[write_count] <= mem_wbyte;
            end
            write_count <= write_count + 1;
        end
    end

    always_comb begin
        rd_base   = {mem_addr[6:2], 2'b00};
        mem_rword = {mem[rd_base], mem[rd_base + 7'd1], mem[rd_base + 7'd2], mem[rd_base + 7'd3]};
    end

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        exp_stall;
        logic        exp_fvalid;
        logic        exp_ffault;
        logic [31:0] exp_finstr;
        logic        exp_dvalid;
        logic [31:0] exp_ddata;
    } vec_t;

    vec_t vecs [0:18];

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic dr, input logic [31:0] da,
                                input logic st, input logic fv, input logic ff, input logic [31:0] fi,
                                input logic dv, input logic [31:0] dd);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_addr = da;
        v.exp_stall = st; v.exp_fvalid = fv; v.exp_ffault = ff; v.exp_finstr = fi;
        v.exp_dvalid = dv; v.exp_ddata = dd;
        return v;
    endfunction

    // One table row = one clock cycle; results of a grant appear two rows later.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(posedge clk); #1;
        fetch_req   = v.f_req;
        fetch_addr  = v.f_addr;
        dbg_rd_req  = v.d_req;
        dbg_rd_addr = v.d_addr;
        @(negedge clk);
        checkOutput($sformatf("row%0d fetch_stall", idx), 32'(fetch_stall), 32'(v.exp_stall));
        checkOutput($sformatf("row%0d fetch_valid", idx), 32'(fetch_valid), 32'(v.exp_fvalid));
        checkOutput($sformatf("row%0d fetch_fault", idx), 32'(fetch_fault), 32'(v.exp_ffault));
        checkOutput($sformatf("row%0d dbg_rd_valid", idx), 32'(dbg_rd_valid), 32'(v.exp_dvalid));
        checkOutput($sformatf("row%0d mem_we", idx), 32'(mem_we), 32'd0);
        if (v.exp_fvalid) checkOutput($sformatf("row%0d fetch_instr", idx), fetch_instr, v.exp_finstr);
        if (v.exp_dvalid) checkOutput($sformatf("row%0d dbg_rd_data", idx), dbg_rd_data, v.exp_ddata);
    endtask

    task automatic read_word(input logic is_dbg, input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        if (is_dbg) begin dbg_rd_req = 1'b1; dbg_rd_addr = addr; end
        else begin fetch_req = 1'b1; fetch_addr = addr; end
        @(posedge clk); #1;
        fetch_req  = 1'b0;
        dbg_rd_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        if (is_dbg) begin
            checkOutput({name, " valid"}, 32'(dbg_rd_valid), 32'd1);
            checkOutput({name, " data"}, dbg_rd_data, exp);
        end else begin
            checkOutput({name, " valid"}, 32'(fetch_valid), 32'd1);
            checkOutput({name, " instr"}, fetch_instr, exp);
        end
    endtask

    logic [7:0] load_bytes [0:255];

    task automatic run_load(input int len, input string tag, output int base);
        logic       seen;
        int         waited;
        logic [7:0] sum;
        base = write_count;
        sum  = 8'h00;
        @(posedge clk); #1;
        dbg_load_start = 1'b1;
        dbg_load_len   = 8'(len);
        @(posedge clk); #1;
        dbg_load_start = 1'b0;
        dbg_load_len   = '0;
        for (int i = 0; i < len; i++) begin
            dbg_byte       = load_bytes[i];
            dbg_byte_valid = 1'b1;
            sum            = sum + load_bytes[i];
            @(negedge clk);
            checkOutput($sformatf("%s byte%0d ready", tag, i), 32'(dbg_byte_ready), 32'd1);
            checkOutput($sformatf("%s byte%0d stall", tag, i), 32'(fetch_stall), 32'd1);
            @(posedge clk); #1;
        end
        dbg_byte_valid = 1'b0;
        dbg_byte       = 8'h00;
        seen   = 1'b0;
        waited = 0;
        for (int c = 1; c <= 6 && !seen; c++) begin
            @(negedge clk);
            if (load_done) begin
                seen   = 1'b1;
                waited = c;
                checkOutput({tag, " done mem_we"}, 32'(mem_we), 32'd0);
                checkOutput({tag, " done stall"}, 32'(fetch_stall), 32'd1);
            end
        end
        checkOutput({tag, " load_done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, " load_done latency"}, 32'(waited), (len == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            checkOutput({tag, " load_done width"}, 32'(load_done), 32'd0);
            checkOutput({tag, " stall after"}, 32'(fetch_stall), 32'd0);
        end
        checkOutput({tag, " writes"}, 32'(write_count - base), 32'((len > MEM_BYTES) ? MEM_BYTES : len));
        checkOutput({tag, " load_ovf"}, 32'(load_ovf), 32'(len > MEM_BYTES));
`ifdef IMEM_CHECKSUM_EN
        checkOutput({tag, " checksum"}, 32'(load_checksum), 32'(sum));
`else
        checkOutput({tag, " checksum"}, 32'(load_checksum), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;

        vecs[0]  = mk(1, 32'h4,        0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 32'h0,        0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0);
        vecs[2]  = mk(0, 32'h0,        0, 32'h0,  0, 1, 0, 32'h8C220004, 0, 32'h0);
        vecs[3]  = mk(0, 32'h0,        1, 32'h8,  0, 0, 0, 32'h0,        0, 32'h0);
        vecs[4]  = mk(0, 32'h0,        0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0);
        vecs[5]  = mk(0, 32'h0,        0, 32'h0,  0, 0, 0, 32'h0,        1, 32'h11223344);
        vecs[6]  = mk(1, 32'hC,        1, 32'h7C, 0, 0, 0, 32'h0,        0, 32'h0);
        vecs[7]  = mk(1, 32'h10,       1, 32'h7C, 1, 0, 0, 32'h0,        0, 32'h0);
        vecs[8]  = mk(1, 32'h10,       0, 32'h0,  0, 1, 0, 32'hDEADBEEF, 0, 32'h0);
        vecs[9]  = mk(0, 32'h0,        0, 32'h0,  0, 0, 0, 32'h0,        1, 32'hCAFEF00D);
        vecs[10] = mk(0, 32'h0,        0, 32'h0,  0, 1, 0, 32'h13579BDF, 0, 32'h0);
        vecs[11] = mk(1, 32'h2,        0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0);
        vecs[12] = mk(1, 32'h7E,       0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0);
        vecs[13] = mk(1, 32'h7C,       0, 32'h0,  0, 1, 1, 32'h0,        0, 32'h0);
        vecs[14] = mk(0, 32'h0,        1, 32'h80, 0, 1, 1, 32'h0,        0, 32'h0);
        vecs[15] = mk(1, 32'hFFFFFFFC, 0, 32'h0,  0, 1, 0, 32'hCAFEF00D, 0, 32'h0);
        vecs[16] = mk(0, 32'h0,        0, 32'h0,  0, 0, 0, 32'h0,        1, 32'h0);
        vecs[17] = mk(0, 32'h0,        0, 32'h0,  0, 1, 1, 32'h0,        0, 32'h0);
        vecs[18] = mk(0, 32'h0,        0, 32'h0,  0, 0, 0, 32'h0,        0, 32'h0);

        // Reset with memory preload; memory content is independent of reset.
        rst_n       = 1'b0;
        preload_now = 1'b1;
        @(posedge clk); #1;
        preload_now = 1'b0;
        @(negedge clk);
        checkOutput("reset fetch_instr", fetch_instr, 32'h0);
        checkOutput("reset fetch_valid", 32'(fetch_valid), 32'd0);
        checkOutput("reset fetch_stall", 32'(fetch_stall), 32'd0);
        checkOutput("reset fetch_fault", 32'(fetch_fault), 32'd0);
        checkOutput("reset dbg_rd_data", dbg_rd_data, 32'h0);
        checkOutput("reset dbg_rd_valid", 32'(dbg_rd_valid), 32'd0);
        checkOutput("reset dbg_byte_ready", 32'(dbg_byte_ready), 32'd0);
        checkOutput("reset load_done", 32'(load_done), 32'd0);
        checkOutput("reset load_ovf", 32'(load_ovf), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_wbyte", 32'(mem_wbyte), 32'd0);
        checkOutput("reset load_checksum", 32'(load_checksum), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] read/arbitration/fault vectors");
        for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

        $display("[TB] load of 8 bytes");
        load_bytes[0] = 8'h20; load_bytes[1] = 8'h01; load_bytes[2] = 8'h00; load_bytes[3] = 8'h05;
        load_bytes[4] = 8'hAA; load_bytes[5] = 8'hBB; load_bytes[6] = 8'hCC; load_bytes[7] = 8'hDD;
        run_load(8, "load8", base);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("load8 wr%0d addr", i), wr_log_addr[base + i], 32'(i));
            checkOutput($sformatf("load8 wr%0d byte", i), 32'(wr_log_byte[base + i]), 32'(load_bytes[i]));
        end
        read_word(1'b0, 32'h0, 32'h20010005, "load8 fetch w0");
        read_word(1'b1, 32'h4, 32'hAABBCCDD, "load8 dbg w1");

        $display("[TB] load of 126 bytes then 4 bytes");
        for (int i = 0; i < 126; i++) load_bytes[i] = 8'(i + 1);
        run_load(126, "load126", base);
        read_word(1'b1, 32'h7C, 32'h7D7EF00D, "load126 w31");
        for (int i = 0; i < 4; i++) load_bytes[i] = 8'(8'hF0 + i);
        run_load(4, "load4", base);
        checkOutput("load4 first addr", wr_log_addr[base], 32'h0);
        read_word(1'b0, 32'h0, 32'hF0F1F2F3, "load4 w0");
        read_word(1'b0, 32'h4, 32'h05060708, "load4 w1");

        $display("[TB] overflowing load and zero-length load");
        for (int i = 0; i < 130; i++) load_bytes[i] = 8'(i) ^ 8'h5A;
        run_load(130, "load130", base);
        checkOutput("load130 no write past end", 32'(bad_write), 32'd0);
        run_load(0, "load0", base);

        $display("[TB] reset during load");
        @(posedge clk); #1;
        dbg_load_start = 1'b1;
        dbg_load_len   = 8'd8;
        @(posedge clk); #1;
        dbg_load_start = 1'b0;
        base = write_count;
        for (int i = 0; i < 3; i++) begin
            dbg_byte       = 8'(8'h31 + i);
            dbg_byte_valid = 1'b1;
            @(posedge clk); #1;
        end
        dbg_byte_valid = 1'b0;
        fetch_req      = 1'b1;
        fetch_addr     = 32'h0;
        @(negedge clk);
        checkOutput("midload stall", 32'(fetch_stall), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort stall", 32'(fetch_stall), 32'd0);
        checkOutput("abort load_done", 32'(load_done), 32'd0);
        checkOutput("abort byte_ready", 32'(dbg_byte_ready), 32'd0);
        checkOutput("abort mem_we", 32'(mem_we), 32'd0);
        fetch_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("abort no load_done c%0d", c), 32'(load_done), 32'd0);
        end
        checkOutput("abort writes", 32'(write_count - base), 32'd3);
        read_word(1'b0, 32'h0, 32'h31323359, "abort w0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
